// File: rtl/ram_arb_pkg.sv
// ram_arbiter shared types.
// State and read-owner encodings.
package ram_arb_pkg;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of CPU wins while host waits.
// Clear has priority over increment.
module arb_starve_ctr #(
  parameter int LIM = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_lim
);

  localparam int W = $clog2(LIM + 1);
  localparam logic [W-1:0] LIM_V = W'(LIM);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != LIM_V) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_lim = (cnt == LIM_V);

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: CPU datapath vs host port.
// Starvation guard plus host lock mode.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state, state_nx;
  owner_t rd_owner, owner_nx;
  logic   cpu_gnt;
  logic   starve_hit;
  logic   cnt_inc, cnt_clr;

  arb_starve_ctr #(
    .LIM(STARVE_LIM)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .at_lim(starve_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ARB;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_ARB:    if (host_gnt && host_lock) state_nx = ST_LOCKED;
      ST_LOCKED: if (!host_lock) state_nx = ST_ARB;
      default:   state_nx = ST_ARB;
    endcase
  end

  // Grants are forced low while reset is held.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (rst_n) begin
      unique case (state)
        ST_ARB: begin
          host_gnt = host_req & (~cpu_req | starve_hit);
          cpu_gnt  = cpu_req & ~host_gnt;
        end
        ST_LOCKED: host_gnt = host_req;
        default: ;
      endcase
    end
  end

  assign cnt_inc = cpu_gnt & host_req;
  assign cnt_clr = host_gnt | ~host_req | (state == ST_LOCKED);

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign locked    = (state == ST_LOCKED);

  always_comb begin
    mem_en    = cpu_gnt | host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      cpu_gnt: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      host_gnt: begin
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_nx = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      owner_nx = OWN_CPU;
    end else if (host_gnt && !host_we) begin
      owner_nx = OWN_HOST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner <= OWN_NONE;
    end else begin
      rd_owner <= owner_nx;
    end
  end

  assign cpu_rvalid  = (rd_owner == OWN_CPU);
  assign host_rvalid = (rd_owner == OWN_HOST);
  assign cpu_rdata   = mem_rdata;
  assign host_rdata  = mem_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed table, reset
// sequence and random traffic against a reference model.
module tb_ram_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          host_req, host_we, host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          locked;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_lock  (host_lock),
    .host_gnt   (host_gnt),
    .host_rdata (host_rdata),
    .host_rvalid(host_rvalid),
    .locked     (locked),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM macro stand-in
  logic [DW-1:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  // reference model state
  logic [DW-1:0] shadow [0:65535];
  bit            m_locked;
  int            m_wait;
  int            m_pend;
  logic [DW-1:0] m_pdata;
  bit            last_hg;
  int            n_tests = 0;
  int            n_fail = 0;
  int            cyc = 0;

  typedef struct {
    logic          cr, cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          hr, hw;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    logic          hl;
    logic          es, eh, el, erc, erh;
    logic [DW-1:0] erd;
  } vec_t;

  vec_t tbl [31];

  function automatic vec_t mk(
    input logic cr, cw, input logic [AW-1:0] ca,
    input logic [DW-1:0] cd,
    input logic hr, hw, input logic [AW-1:0] ha,
    input logic [DW-1:0] hd, input logic hl,
    input logic es, eh, el, erc, erh,
    input logic [DW-1:0] erd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd;
    v.hl = hl; v.es = es; v.eh = eh; v.el = el;
    v.erc = erc; v.erh = erh; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_wait   = 0;
    m_pend   = 0;
    m_pdata  = '0;
    last_hg  = 0;
  endtask

  // Expected behaviour for the current cycle, then advance.
  task automatic model_cycle();
    bit            eg_c, eg_h;
    int            np;
    logic [DW-1:0] nd;
    if (m_locked) begin
      eg_h = host_req;
      eg_c = 0;
    end else begin
      eg_h = host_req && (!cpu_req || m_wait >= LIM);
      eg_c = cpu_req && !eg_h;
    end
    chk("cpu_stall", cpu_stall, cpu_req && !eg_c);
    chk("host_gnt", host_gnt, eg_h);
    chk("locked", locked, m_locked);
    chk("mem_en", mem_en, eg_c || eg_h);
    chk("mem_we", mem_we,
        eg_c ? cpu_we : (eg_h && host_we));
    chk("mem_addr", mem_addr,
        eg_c ? cpu_addr : (eg_h ? host_addr : '0));
    chk("mem_wdata", mem_wdata,
        eg_c ? cpu_wdata : (eg_h ? host_wdata : '0));
    chk("cpu_rvalid", cpu_rvalid, m_pend == 1);
    chk("host_rvalid", host_rvalid, m_pend == 2);
    if (m_pend == 1) chk("cpu_rdata", cpu_rdata, m_pdata);
    if (m_pend == 2) chk("host_rdata", host_rdata, m_pdata);
    np = 0;
    nd = '0;
    if (eg_c && !cpu_we) begin
      np = 1;
      nd = shadow[cpu_addr];
    end else if (eg_h && !host_we) begin
      np = 2;
      nd = shadow[host_addr];
    end
    if (eg_c && cpu_we) shadow[cpu_addr] = cpu_wdata;
    if (eg_h && host_we) shadow[host_addr] = host_wdata;
    m_pend  = np;
    m_pdata = nd;
    if (!m_locked && eg_c && host_req)
      m_wait = (m_wait < LIM) ? m_wait + 1 : LIM;
    else
      m_wait = 0;
    m_locked = m_locked ? host_lock : (eg_h && host_lock);
    last_hg  = eg_h;
    cyc++;
  endtask

  task automatic run_cycle();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v);
    cpu_req = v.cr; cpu_we = v.cw;
    cpu_addr = v.ca; cpu_wdata = v.cd;
    host_req = v.hr; host_we = v.hw;
    host_addr = v.ha; host_wdata = v.hd;
    host_lock = v.hl;
    @(negedge clk);
    chk("tbl_stall", cpu_stall, v.es);
    chk("tbl_hgnt", host_gnt, v.eh);
    chk("tbl_locked", locked, v.el);
    chk("tbl_crv", cpu_rvalid, v.erc);
    chk("tbl_hrv", host_rvalid, v.erh);
    if (v.erc) chk("tbl_crd", cpu_rdata, v.erd);
    if (v.erh) chk("tbl_hrd", host_rdata, v.erd);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    ram[a]    = d;
    shadow[a] = d;
  endtask

  initial begin
    rst_n = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0;
    host_wdata = '0; host_lock = 0;
    for (int a = 0; a < 65536; a++) begin
      ram[a]    = 8'(a) ^ 8'h5A;
      shadow[a] = 8'(a) ^ 8'h5A;
    end
    preload(16'h1234, 8'hA5);
    preload(16'h0020, 8'h11);
    preload(16'h0030, 8'h22);
    model_reset();

    // held in reset
    #12;
    chk("rst_locked", locked, 1'b0);
    chk("rst_hgnt", host_gnt, 1'b0);
    chk("rst_men", mem_en, 1'b0);
    chk("rst_crv", cpu_rvalid, 1'b0);
    chk("rst_hrv", host_rvalid, 1'b0);
    cpu_req = 1; host_req = 1;
    #1;
    chk("rst_stall", cpu_stall, 1'b1);
    chk("rst_hgnt_req", host_gnt, 1'b0);
    chk("rst_men_req", mem_en, 1'b0);
    cpu_req = 0; host_req = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    tbl[0]  = mk(0,0,0,0,       0,0,0,0,0,       0,0,0,0,0,0);
    tbl[1]  = mk(0,0,0,0,       1,0,16'h1234,0,0, 0,1,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,       0,0,0,0,0,       0,0,0,0,1,8'hA5);
    tbl[3]  = mk(1,1,16'h10,8'h3C, 1,0,16'h10,0,0, 0,0,0,0,0,0);
    tbl[4]  = mk(0,0,0,0,       1,0,16'h10,0,0,  0,1,0,0,0,0);
    tbl[5]  = mk(0,0,0,0,       0,0,0,0,0,       0,0,0,0,1,8'h3C);
    for (int i = 6; i < 10; i++)
      tbl[i] = mk(1,1,16'h40,8'h77, 1,0,16'h10,0,0, 0,0,0,0,0,0);
    tbl[10] = mk(1,1,16'h40,8'h77, 1,0,16'h10,0,0, 1,1,0,0,0,0);
    tbl[11] = mk(1,1,16'h40,8'h77, 0,0,0,0,0, 0,0,0,0,1,8'h3C);
    tbl[12] = mk(0,0,0,0,  1,1,16'h0,8'h99,1, 0,1,0,0,0,0);
    for (int k = 1; k <= 8; k++)
      tbl[12+k] = mk(1,0,16'h20,0, 1,1,16'(k),8'(8'hB0 + k),1,
                     1,1,1,0,0,0);
    tbl[21] = mk(1,0,16'h20,0, 0,0,0,0,0,  1,0,1,0,0,0);
    tbl[22] = mk(1,0,16'h20,0, 0,0,0,0,0,  0,0,0,0,0,0);
    tbl[23] = mk(0,0,0,0, 1,0,16'h30,0,0,  0,1,0,1,0,8'h11);
    tbl[24] = mk(1,0,16'h3,0, 0,0,0,0,0,   0,0,0,0,1,8'h22);
    tbl[25] = mk(0,0,0,0, 1,0,16'h5,0,0,   0,1,0,1,0,8'hB3);
    tbl[26] = mk(0,0,0,0, 0,0,0,0,0,       0,0,0,0,1,8'hB5);
    tbl[27] = mk(0,0,0,0, 1,1,16'h100,8'hC1,1, 0,1,0,0,0,0);
    tbl[28] = mk(1,0,16'h20,0, 1,1,16'h101,8'hC2,0,
                 1,1,1,0,0,0);
    tbl[29] = mk(1,0,16'h20,0, 0,0,0,0,0,  0,0,0,0,0,0);
    tbl[30] = mk(0,0,0,0, 0,0,0,0,0,       0,0,0,1,0,8'h11);
    foreach (tbl[i]) apply_vec(tbl[i]);

    // reset pulse while a CPU read is outstanding
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    run_cycle();
    cpu_req = 0;
    chk("pre_rst_crv", cpu_rvalid, 1'b1);
    rst_n = 0;
    #1;
    chk("mid_rst_crv", cpu_rvalid, 1'b0);
    chk("mid_rst_hrv", host_rvalid, 1'b0);
    chk("mid_rst_locked", locked, 1'b0);
    chk("mid_rst_men", mem_en, 1'b0);
    cpu_req = 1; host_req = 1;
    #1;
    chk("mid_rst_stall", cpu_stall, 1'b1);
    chk("mid_rst_hgnt", host_gnt, 1'b0);
    chk("mid_rst_maddr", mem_addr, '0);
    cpu_req = 0; host_req = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;
    run_cycle();
    run_cycle();

    // random traffic; host fields held until granted
    for (int i = 0; i < 3000; i++) begin
      cpu_req   = ($urandom_range(0, 9) < 7);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 16'($urandom_range(0, 15));
      cpu_wdata = 8'($urandom);
      if (!(host_req && !last_hg)) begin
        host_req   = 1'($urandom_range(0, 1));
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = 16'($urandom_range(0, 15));
        host_wdata = 8'($urandom);
        host_lock  = m_locked ? ($urandom_range(0, 9) < 8)
                              : ($urandom_range(0, 9) < 1);
      end
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Arbitrates the single-port main RAM between the CPU datapath (microcode-driven MAR/RAM accesses) and an external host loader/debug port. One access per clock; the loser is stalled. A starvation guard bounds host wait, and a lock mode gives the host exclusive ownership for program loading. Sits between the CPU core, the host interface and the RAM macro.

## Interface
- `ADDR_W`, 16, address width (matches 16-bit MAR)
- `DATA_W`, 8, data width
- `STARVE_LIM`, 4, max consecutive CPU grants while host waits (1..15)

- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU wants RAM this cycle (OR of RAM_LOAD/RAM_ENH/RAM_ENL)
- `cpu_we`  in  1  1 = write
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`; CPU holds its microcode stage
- `cpu_rdata`  out  DATA_W  read data
- `cpu_rvalid`  out  1  `cpu_rdata` valid this cycle
- `host_req`  in  1  host access request; held with fields stable until `host_gnt`
- `host_we`, `host_addr`, `host_wdata`  in  1/ADDR_W/DATA_W  host access fields
- `host_lock`  in  1  request exclusive ownership
- `host_gnt`  out  1  host access issued this cycle
- `host_rdata`  out  DATA_W  read data
- `host_rvalid`  out  1  `host_rdata` valid this cycle
- `locked`  out  1  arbiter in LOCKED state
- `mem_en`, `mem_we`  out  1  RAM strobes
- `mem_addr`, `mem_wdata`  out  ADDR_W/DATA_W  RAM address/data
- `mem_rdata`  in  DATA_W  RAM read data, valid one cycle after a read

## Operation
- States: ARB (reset), LOCKED.
- ARB grant (combinational): CPU wins when `cpu_req`, unless `host_req & (starve_cnt == STARVE_LIM)`; host wins when `host_req` and CPU does not.
- `starve_cnt`: +1 on each edge where CPU granted and `host_req` high; cleared when host granted or `host_req` low; saturates at STARVE_LIM.
- ARB -> LOCKED on an edge where host granted with `host_lock=1`.
- LOCKED: host granted whenever `host_req`; CPU never granted (`cpu_stall = cpu_req`); `starve_cnt` held at 0.
- LOCKED -> ARB on the first edge sampling `host_lock=0`, regardless of `host_req`.
- Mem mux: `mem_en = cpu_gnt | host_gnt`; fields from the granted requester; all zero when idle.
- Read return: register `rd_owner` (NONE/CPU/HOST) set on granted read; next cycle `<owner>_rvalid=1`; both rdata outputs = `mem_rdata` unconditionally. Writes produce no rvalid.
- While `rst_n=0`: all grants 0, `mem_en=0`, `cpu_stall=cpu_req`.

## Timing
- Reset values: state ARB, `starve_cnt=0`, `rd_owner=NONE`, `locked=0`, `cpu_rvalid=host_rvalid=0`, `host_gnt=0`, `mem_*=0`.
- Grant/stall same cycle as request; read latency 1 cycle after grant.
- Host waits at most STARVE_LIM cycles behind continuous CPU traffic (grant in cycle STARVE_LIM+1).
- Back-to-back reads: rvalid each cycle, owner tracks per access.
- Reset asserted mid-read: pending rvalid dropped; none after release.
- `locked` is registered; reflects the state of the current cycle.
- `host_lock` dropped and `host_req` high in same cycle: that access still granted (LOCKED), ARB next cycle.

## Structure
- Shared package/include `ram_arb_pkg`: state encoding (ST_ARB, ST_LOCKED), owner encoding (OWN_NONE, OWN_CPU, OWN_HOST).
- One sub-module natural: `arb_starve_ctr` (saturating counter with clear, width from STARVE_LIM).
- Grant logic, state register and read-return register stay in the top module.

## Test plan
- Idle CPU, host read 0x1234 (RAM holds 0xA5) -> `host_gnt` same cycle, `host_rvalid=1`, `host_rdata=0xA5` next cycle.
- Simultaneous CPU write 0x0010=0x3C and host read 0x0010 -> CPU granted, host stalled one cycle, then host reads 0x3C.
- `cpu_req` held high 10 cycles, host_req high, STARVE_LIM=4 -> CPU granted cycles 1-4, host cycle 5, CPU resumes cycle 6.
- Host write 0x0000 with `host_lock=1`, then 8 host writes while `cpu_req` high -> `locked=1`, `cpu_stall=1` throughout; `host_lock=0` -> CPU granted next cycle.
- CPU read issued, `rst_n` pulsed low before next edge -> no `cpu_rvalid`; all outputs at reset values.
- Alternating CPU/host reads each cycle -> rvalid routed to correct owner with correct data every cycle.
